// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: keeps a single sequential fetch in flight to a variable-latency
// instruction memory and queues returned words with their PC+4 for the fetch stage.
module inst_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fe_valid,
  output logic [31:0] fe_inst,
  output logic [31:0] fe_pc_plus4,
  input  logic        fe_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

  logic [31:0]        inst_mem [DEPTH];
  logic [31:0]        pc4_mem  [DEPTH];

  logic [31:0]        target_pc;
  logic               push;
  logic               pop;
  logic               credit;

  assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
  assign mem_req     = (state_q == REQ) || (state_q == DROP);
  assign mem_addr    = req_addr_q;
  assign fe_valid    = (count_q != '0);
  assign fe_inst     = inst_mem[rd_ptr_q];
  assign fe_pc_plus4 = pc4_mem[rd_ptr_q];

  // A word is kept only if it answers a live request; stale (DROP) and redirected acks are lost.
  assign push = (state_q == REQ) && mem_ack && !redirect;
  assign pop  = fe_valid && fe_ready && !redirect;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // Credit looks at the post-update occupancy so a slot freed this cycle can be reused at once.
    credit = (count_d < DEPTH_C);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      IDLE: begin
        // A redirect empties the FIFO, so it can always launch straight away.
        if (redirect) begin
          state_d    = REQ;
          req_addr_d = target_pc;
          fetch_pc_d = target_pc + 32'd4;
        end else if (credit) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      REQ: begin
        if (redirect) begin
          if (mem_ack) begin
            req_addr_d = target_pc;
            fetch_pc_d = target_pc + 32'd4;
          end else begin
            state_d    = DROP;
            fetch_pc_d = target_pc;
          end
        end else if (mem_ack) begin
          if (credit) begin
            req_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_d = REQ;
          if (redirect) begin
            req_addr_d = target_pc;
            fetch_pc_d = target_pc + 32'd4;
          end else begin
            req_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect) begin
          fetch_pc_d = target_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only ever read while count marks it valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= mem_rdata;
      pc4_mem[wr_ptr_q]  <= req_addr_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch: queue-based reference model, scoreboard monitor,
// scripted memory with variable latency, directed scenarios then a randomized soak.
module tb_inst_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fe_valid;
  logic [31:0] fe_inst;
  logic [31:0] fe_pc_plus4;
  logic        fe_ready;

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fe_valid    (fe_valid),
    .fe_inst     (fe_inst),
    .fe_pc_plus4 (fe_pc_plus4),
    .fe_ready    (fe_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_cnt  = 0;
  bit          armed    = 1'b0;

  // memory behaviour controls
  bit          lat_rand  = 1'b0;
  bit          rand_data = 1'b0;
  bit          mem_hold  = 1'b0;
  int unsigned lat_fix   = 0;

  // reference model state
  entry_t      sb_q[$];
  logic [31:0] exp_fetch = RESET_PC;
  bit          stale     = 1'b0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: acks after a per-request latency, abandons everything while reset is high.
  initial begin
    bit          busy = 1'b0;
    int unsigned wait_cnt = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset !== 1'b0) begin
        mem_ack = 1'b0;
        busy    = 1'b0;
      end else if (mem_req === 1'b1) begin
        if (!busy) begin
          busy     = 1'b1;
          wait_cnt = lat_rand ? $urandom_range(0, 3) : lat_fix;
        end
        if (wait_cnt == 0 && !mem_hold) begin
          mem_ack = 1'b1;
          busy    = 1'b0;
        end else begin
          mem_ack = 1'b0;
          if (wait_cnt != 0) wait_cnt--;
        end
      end else begin
        mem_ack = 1'b0;
        busy    = 1'b0;
      end
      mem_rdata = rand_data ? $urandom : (mem_addr ^ 32'hA5A5_0000);
    end
  end

  // Monitor: occupancy must match the model, and every consumed word must be the model's head.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        check("fe_valid", 32'(fe_valid), 32'(sb_q.size() != 0));
        if (fe_valid === 1'b1 && fe_ready && !redirect && !reset && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("fe_inst", fe_inst, e.inst);
          check("fe_pc_plus4", fe_pc_plus4, e.pc4);
        end
      end
    end
  end

  // Reference model: sequential fetch stream from the last restart point; at most one stale ack.
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      #1;
      if (armed) begin
        if (reset) begin
          sb_q.delete();
          exp_fetch = RESET_PC;
          stale     = 1'b0;
          prev_pend = 1'b0;
        end else begin
          if (prev_pend) begin
            check("req_held", 32'(mem_req), 32'd1);
            check("addr_held", mem_addr, prev_addr);
          end
          hs = (mem_req === 1'b1) && mem_ack;
          if (hs) ack_cnt++;
          if (redirect) begin
            if (hs) stale = 1'b0;
            else if (mem_req === 1'b1) stale = 1'b1;
            exp_fetch = redirect_pc & 32'hFFFF_FFFC;
            sb_q.delete();
          end else if (hs) begin
            if (stale) begin
              stale = 1'b0;
            end else begin
              check("req_addr", mem_addr, exp_fetch);
              check("push_not_full", 32'(sb_q.size() < DEPTH), 32'd1);
              sb_q.push_back(entry_t'{inst: mem_rdata, pc4: exp_fetch + 32'd4});
              exp_fetch = exp_fetch + 32'd4;
            end
          end
          prev_pend = (mem_req === 1'b1) && !mem_ack;
          prev_addr = mem_addr;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int held;
    int guard;

    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    fe_ready    = 1'b0;
    tick();
    armed = 1'b1;
    tick();
    tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_fe_valid", 32'(fe_valid), 32'd0);

    // Streaming with single-cycle acks
    reset    = 1'b0;
    fe_ready = 1'b1;
    check("idle_before_edge", 32'(mem_req), 32'd0);
    tick();
    check("first_req", 32'(mem_req), 32'd1);
    for (int k = 0; k < 16; k++) begin
      check("stream_addr", mem_addr, RESET_PC + 32'(k * 4));
      tick();
      check("stream_no_gap", 32'(fe_valid), 32'd1);
    end

    // Back-pressure from reset
    reset    = 1'b1;
    fe_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    base  = ack_cnt;
    repeat (10) tick();
    check("bp_acks", 32'(ack_cnt - base), 32'd4);
    check("bp_req_low", 32'(mem_req), 32'd0);
    check("bp_valid", 32'(fe_valid), 32'd1);
    fe_ready = 1'b1;
    tick();
    fe_ready = 1'b0;
    check("bp_refill_req", 32'(mem_req), 32'd1);
    check("bp_refill_addr", mem_addr, 32'd16);
    tick();
    check("bp_refill_done", 32'(mem_req), 32'd0);
    repeat (3) tick();
    check("bp_one_more_ack", 32'(ack_cnt - base), 32'd5);

    // Redirect while idle and full
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    check("ridle_flush", 32'(fe_valid), 32'd0);
    check("ridle_req", 32'(mem_req), 32'd1);
    check("ridle_addr", mem_addr, 32'h0000_0100);
    fe_ready = 1'b1;
    tick();
    check("ridle_addr2", mem_addr, 32'h0000_0104);
    check("ridle_valid", 32'(fe_valid), 32'd1);
    check("ridle_pc4", fe_pc_plus4, 32'h0000_0104);

    // Redirect while a slow request is pending
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0020;
    tick();
    lat_fix     = 3;
    redirect_pc = 32'h0000_0400;
    check("pend_addr", mem_addr, 32'h0000_0020);
    tick();
    redirect = 1'b0;
    lat_fix  = 0;
    held     = 0;
    while (mem_req === 1'b1 && mem_addr == 32'h0000_0020 && held < 10) begin
      held++;
      tick();
    end
    check("pend_hold_cycles", 32'(held), 32'd3);
    check("pend_new_req", 32'(mem_req), 32'd1);
    check("pend_new_addr", mem_addr, 32'h0000_0400);

    // Redirect coincident with ack and pop
    repeat (4) tick();
    check("coinc_pre_valid", 32'(fe_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0080;
    tick();
    redirect = 1'b0;
    check("coinc_flush", 32'(fe_valid), 32'd0);
    check("coinc_req", 32'(mem_req), 32'd1);
    check("coinc_addr", mem_addr, 32'h0000_0080);

    // Reset mid-stream with three entries and a request pending
    fe_ready = 1'b0;
    guard    = 0;
    while (sb_q.size() != 3 && guard < 20) begin
      guard++;
      tick();
    end
    check("fill_in_time", 32'(guard < 20), 32'd1);
    check("mid_pending", 32'(mem_req), 32'd1);
    check("mid_valid", 32'(fe_valid), 32'd1);
    reset    = 1'b1;
    mem_hold = 1'b1;
    tick();
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_valid", 32'(fe_valid), 32'd0);
    check("mid_rst_addr", mem_addr, RESET_PC);
    reset    = 1'b0;
    mem_hold = 1'b0;
    fe_ready = 1'b1;
    tick();
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, RESET_PC);
    tick();
    check("restart_pc4", fe_pc_plus4, RESET_PC + 32'd4);

    // Address wrap and low-bit masking of the redirect target
    repeat (2) tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_next_addr", mem_addr, 32'h0000_0000);
    check("wrap_valid", 32'(fe_valid), 32'd1);
    check("wrap_pc4", fe_pc_plus4, 32'h0000_0000);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    check("mask_addr", mem_addr, 32'h0000_0200);

    // Randomized soak
    lat_rand  = 1'b1;
    rand_data = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      fe_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      reset       = ($urandom_range(0, 499) == 0);
      tick();
    end

    // Drain with memory stalled
    reset    = 1'b0;
    redirect = 1'b0;
    fe_ready = 1'b1;
    mem_hold = 1'b1;
    repeat (12) tick();
    check("drain_empty", 32'(fe_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
